atax_seq: RTL
=============

ATAX_SEQ -- requirements
Module: atax_seq

Interface
REQ-001 SHALL have parameter N, default 64, meaning matrix dimension; legal values are powers of two from 4 to 256.
REQ-002 SHALL have parameter AW, default 6, meaning index width, equal to log2(N).
REQ-003 SHALL have port clk, input, 1, the only clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to begin one ATAX pass; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1, cancel the pass in progress.
REQ-007 SHALL have port opnd_vld, input, 1, operands for the current address are available; low stalls issue.
REQ-008 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when a pass completes.
REQ-010 SHALL have port phase, output, 1: 0 while computing tmp1 = A*x, 1 while computing y = A'*tmp1.
REQ-011 SHALL have port row, output, AW, row index i of A for the current issue.
REQ-012 SHALL have port col, output, AW, column index j of A for the current issue.
REQ-013 SHALL have port mac_en, output, 1, accumulate the product at row/col this cycle.
REQ-014 SHALL have port mac_clr, output, 1, the accumulator loads the product instead of adding it (first term of a dot product).
REQ-015 SHALL have port wr_en, output, 1, write the accumulator to the result buffer this cycle.
REQ-016 SHALL have port wr_sel, output, 1: 0 selects the tmp1 buffer, 1 selects the y buffer.
REQ-017 SHALL have port wr_idx, output, AW, destination element index.
REQ-018 SHALL have port cyc_cnt, output, 32, number of busy cycles in the last completed pass.

Function
REQ-019 SHALL implement states IDLE, P1, WB1, P2, WB2, DONE.
REQ-020 SHALL move from IDLE to P1 on start=1, with i=0 and j=0.
REQ-021 In P1, SHALL drive row=i and col=j, with j as the inner loop.
REQ-022 In P1, SHALL assert mac_en=opnd_vld, and SHALL assert mac_clr=opnd_vld when j=0.
REQ-023 In P1, when opnd_vld=1, SHALL increment j; after issuing j=N-1 it SHALL go to WB1.
REQ-024 WB1 SHALL last one cycle with wr_en=1, wr_sel=0, wr_idx=i, then set i=i+1 and j=0.
REQ-025 After WB1, if i was N-1, SHALL go to P2 with i=0 and j=0; otherwise SHALL return to P1.
REQ-026 P2 SHALL mirror P1 with i as the inner loop (row=i, col=j), and SHALL assert mac_clr when i=0.
REQ-027 After issuing i=N-1 in P2, SHALL go to WB2: wr_sel=1, wr_idx=j, then j=j+1.
REQ-028 After WB2, if j was N-1, SHALL go to DONE; otherwise SHALL return to P2.
REQ-029 DONE SHALL last one cycle: done=1, busy=1, and cyc_cnt updated; the next state is IDLE.
REQ-030 With no stalls, a pass SHALL take exactly 2*(N*N+N)+1 busy cycles, from the first P1 cycle through DONE.
REQ-031 When opnd_vld=0 in P1/P2, SHALL hold i, j and state; mac_en=0 and mac_clr=0; the stalled cycles count toward cyc_cnt.
REQ-032 opnd_vld SHALL be ignored in WB1, WB2, DONE and IDLE.
REQ-033 SHALL ignore start while busy=1.
REQ-034 abort=1 in any busy state SHALL force IDLE at the next edge; it has priority over every other transition.
REQ-035 On abort, SHALL NOT assert done or wr_en in the aborted cycle and SHALL leave cyc_cnt unchanged.
REQ-036 If start and abort are both high in IDLE, abort SHALL win and the block SHALL stay IDLE.
REQ-037 mac_en, mac_clr and wr_en SHALL never be high in the same cycle as each other's conflicting write: mac_* only in P1/P2, wr_en only in WB1/WB2.
REQ-038 phase SHALL be 0 in IDLE, P1 and WB1, and 1 in P2, WB2 and DONE.

Reset
REQ-039 reset=1 SHALL force IDLE at the next edge, overriding start and abort, including mid-pass.
REQ-040 After reset, SHALL hold i=j=0, busy=0, done=0, phase=0, row=col=0, mac_en=mac_clr=wr_en=0, wr_sel=0, wr_idx=0 and cyc_cnt=0.

Verification
REQ-041 Bench SHALL cover: N=4, start pulse, opnd_vld=1 throughout -> done exactly 41 cycles after the first P1 cycle, cyc_cnt=41, 8 wr_en pulses with wr_idx 0..3 at wr_sel=0 then 0..3 at wr_sel=1.
REQ-042 Bench SHALL cover: N=4, issue order check -> P1 issues (0,0),(0,1),(0,2),(0,3),WB, (1,0)...; P2 issues (0,0),(1,0),(2,0),(3,0),WB, (0,1)...; mac_clr only on the first issue of each group.
REQ-043 Bench SHALL cover: N=4, opnd_vld low for 3 cycles at P1 (1,2) -> row/col held at (1,2), mac_en=0 during the stall, cyc_cnt=44.
REQ-044 Bench SHALL cover: abort during P2 (2,1) -> IDLE next cycle, no done, cyc_cnt retains its previous value, and a new start runs a full 41-cycle pass.
REQ-045 Bench SHALL cover: reset asserted in WB1 -> all outputs at their reset values next cycle, with no wr_en pulse.
REQ-046 Bench SHALL cover: start held high through a pass -> the second pass begins the cycle after DONE (IDLE for one cycle), and start is ignored while busy.

Source files
------------

// File: rtl/atax_seq.sv
// Control sequencer for ATAX: tmp1 = A*x, then y = A'*tmp1.
// Issues (row, col) MAC addresses and result-buffer writebacks.
module atax_seq #(
    parameter int N  = 64,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          opnd_vld,
    output logic          busy,
    output logic          done,
    output logic          phase,
    output logic [AW-1:0] row,
    output logic [AW-1:0] col,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          wr_en,
    output logic          wr_sel,
    output logic [AW-1:0] wr_idx,
    output logic [31:0]   cyc_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        P1,
        WB1,
        P2,
        WB2,
        DONE
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t        state;
    logic [AW-1:0] i;
    logic [AW-1:0] j;
    logic [31:0]   cnt;
    logic          issue;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            i       <= '0;
            j       <= '0;
            cnt     <= '0;
            cyc_cnt <= '0;
        end else if (abort) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
        end else begin
            if (state != IDLE)
                cnt <= cnt + 32'd1;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= P1;
                        i     <= '0;
                        j     <= '0;
                        cnt   <= '0;
                    end
                end
                P1: begin
                    if (opnd_vld) begin
                        j <= j + 1'b1;
                        if (j == LAST)
                            state <= WB1;
                    end
                end
                WB1: begin
                    i     <= i + 1'b1;
                    j     <= '0;
                    state <= (i == LAST) ? P2 : P1;
                end
                P2: begin
                    if (opnd_vld) begin
                        i <= i + 1'b1;
                        if (i == LAST)
                            state <= WB2;
                    end
                end
                WB2: begin
                    i     <= '0;
                    j     <= j + 1'b1;
                    state <= (j == LAST) ? DONE : P2;
                end
                DONE: begin
                    // cnt excludes the DONE cycle itself
                    cyc_cnt <= cnt + 32'd1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign issue   = ((state == P1) || (state == P2)) && opnd_vld;
    assign busy    = (state != IDLE);
    assign phase   = (state == P2) || (state == WB2) || (state == DONE);
    assign row     = i;
    assign col     = j;
    assign mac_en  = issue;
    assign mac_clr = issue && ((state == P1) ? (j == '0) : (i == '0));
    // a cancelled cycle must not commit a result or signal completion
    assign wr_en   = ((state == WB1) || (state == WB2)) && !abort && !reset;
    assign wr_sel  = (state == WB2);
    assign wr_idx  = (state == WB2) ? j : i;
    assign done    = (state == DONE) && !abort && !reset;

endmodule
